parity_rx_check: RTL and testbench

- Receive-side counterpart of the XOR parity generator.
- Deserialises a bit-serial frame of DATA_WIDTH data bits (LSB first) followed by one even-parity bit, recomputes the parity, and presents the word plus an error flag on a valid/ready output port.
- Keeps a saturating parity-error counter and a sticky error flag for status readout.
- Sits between a serial link front-end and the word-level datapath.

---
 rtl/parity_pkg.sv | 18 +
 rtl/parity_rx_check_if.sv | 23 ++
 rtl/sat_counter.sv | 26 ++
 rtl/parity_rx_check.sv | 117 +++++++++++
 tb/tb_parity_rx_check.sv | 201 ++++++++++++++++++++
 5 files changed

// File: rtl/parity_pkg.sv
// Shared types and helpers for the serial parity receive checker.
package parity_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SHIFT,
        ST_PARITY,
        ST_OUT
    } state_t;

    localparam logic PARITY_EVEN = 1'b0;

    // Width of a bit index into a DATA_WIDTH-bit word (never below 1).
    function automatic int unsigned idx_width(input int unsigned width);
        return (width <= 1) ? 1 : $clog2(width);
    endfunction

endpackage

// File: rtl/parity_rx_check_if.sv
// Serial input and word-level valid/ready output of the parity receive checker.
interface parity_rx_check_if #(
    parameter int unsigned DATA_WIDTH = 64
);
    logic                  ser_valid_i;
    logic                  ser_bit_i;
    logic                  ser_first_i;
    logic                  ser_ready_o;
    logic                  out_valid_o;
    logic                  out_ready_i;
    logic [DATA_WIDTH-1:0] out_data_o;
    logic                  out_err_o;

    modport master (
        output ser_valid_i, ser_bit_i, ser_first_i, out_ready_i,
        input  ser_ready_o, out_valid_o, out_data_o, out_err_o
    );

    modport slave (
        input  ser_valid_i, ser_bit_i, ser_first_i, out_ready_i,
        output ser_ready_o, out_valid_o, out_data_o, out_err_o
    );
endinterface

// File: rtl/sat_counter.sv
// Saturating up-counter; a clear coinciding with an increment leaves the count at 1.
module sat_counter #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             clr_i,
    input  logic             inc_i,
    output logic [WIDTH-1:0] cnt_o
);

    logic [WIDTH-1:0] r_cnt;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_cnt <= '0;
        end else if (clr_i) begin
            r_cnt <= WIDTH'(inc_i);
        end else if (inc_i && (r_cnt != '1)) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign cnt_o = r_cnt;

endmodule

// File: rtl/parity_rx_check.sv
// Deserialises LSB-first frames with a trailing even-parity bit and flags mismatches.
module parity_rx_check
    import parity_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 64,
    parameter int unsigned CNT_WIDTH  = 16
) (
    input  logic                 clk_i,
    input  logic                 rst_n_i,
    parity_rx_check_if.slave     bus,
    output logic                 err_sticky_o,
    output logic [CNT_WIDTH-1:0] err_cnt_o,
    input  logic                 err_clr_i
);

    localparam int unsigned           IDX_W    = idx_width(DATA_WIDTH);
    localparam logic [IDX_W-1:0]      LAST_IDX = IDX_W'(DATA_WIDTH - 1);

    state_t                r_state;
    state_t                w_next;
    logic [DATA_WIDTH-1:0] r_shift;
    logic [DATA_WIDTH-1:0] r_data;
    logic [IDX_W-1:0]      r_idx;
    logic                  r_par;
    logic                  r_err;
    logic                  r_sticky;
    logic                  w_xfer;
    logic                  w_err_inc;

    assign bus.ser_ready_o = (r_state != ST_OUT);
    assign bus.out_valid_o = (r_state == ST_OUT);
    assign bus.out_data_o  = r_data;
    assign bus.out_err_o   = r_err;

    assign w_xfer    = bus.ser_valid_i & bus.ser_ready_o;
    assign w_err_inc = bus.out_valid_o & bus.out_ready_i & r_err;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_xfer && bus.ser_first_i) w_next = ST_SHIFT;
            end
            ST_SHIFT: begin
                // A new-frame marker restarts the frame, so it stays in SHIFT.
                if (w_xfer && !bus.ser_first_i && (r_idx == LAST_IDX)) w_next = ST_PARITY;
            end
            ST_PARITY: begin
                if (w_xfer) w_next = ST_OUT;
            end
            ST_OUT: begin
                if (bus.out_ready_i) w_next = ST_IDLE;
            end
            default: w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_shift <= '0;
            r_idx   <= '0;
            r_par   <= 1'b0;
            r_data  <= '0;
            r_err   <= 1'b0;
        end else if (w_xfer) begin
            case (r_state)
                ST_IDLE, ST_SHIFT: begin
                    if (bus.ser_first_i) begin
                        r_shift <= DATA_WIDTH'(bus.ser_bit_i);
                        r_idx   <= IDX_W'(1);
                        r_par   <= bus.ser_bit_i;
                    end else if (r_state == ST_SHIFT) begin
                        r_shift[r_idx] <= bus.ser_bit_i;
                        r_idx          <= r_idx + 1'b1;
                        r_par          <= r_par ^ bus.ser_bit_i;
                    end
                end
                ST_PARITY: begin
                    r_data <= r_shift;
                    r_err  <= r_par ^ bus.ser_bit_i ^ PARITY_EVEN;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_sticky <= 1'b0;
        end else if (err_clr_i) begin
            r_sticky <= w_err_inc;
        end else if (w_err_inc) begin
            r_sticky <= 1'b1;
        end
    end

    assign err_sticky_o = r_sticky;

    sat_counter #(
        .WIDTH (CNT_WIDTH)
    ) u_err_cnt (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .clr_i   (err_clr_i),
        .inc_i   (w_err_inc),
        .cnt_o   (err_cnt_o)
    );

endmodule

// File: tb/tb_parity_rx_check.sv
// Directed-vector bench for parity_rx_check with DATA_WIDTH = 8, CNT_WIDTH = 4.
module tb_parity_rx_check;

    localparam int unsigned DW = 8;
    localparam int unsigned CW = 4;

    logic          clk     = 1'b0;
    logic          rst_n   = 1'b0;
    logic          err_clr = 1'b0;
    logic          err_sticky;
    logic [CW-1:0] err_cnt;

    int unsigned n_vec = 0;
    int unsigned n_err = 0;

    parity_rx_check_if #(.DATA_WIDTH(DW)) bus ();

    parity_rx_check #(
        .DATA_WIDTH (DW),
        .CNT_WIDTH  (CW)
    ) dut (
        .clk_i        (clk),
        .rst_n_i      (rst_n),
        .bus          (bus),
        .err_sticky_o (err_sticky),
        .err_cnt_o    (err_cnt),
        .err_clr_i    (err_clr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One bit offered for exactly one clock; returns 1 time unit after that edge.
    task automatic send_bit(input logic first, input logic b);
        @(negedge clk);
        bus.ser_valid_i = 1'b1;
        bus.ser_first_i = first;
        bus.ser_bit_i   = b;
        @(posedge clk);
        #1;
        bus.ser_valid_i = 1'b0;
        bus.ser_first_i = 1'b0;
    endtask

    task automatic send_data(input logic [DW-1:0] d);
        for (int i = 0; i < int'(DW); i++) send_bit(i == 0, d[i]);
    endtask

    task automatic send_frame(input logic [DW-1:0] d, input logic p);
        send_data(d);
        send_bit(1'b0, p);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        bus.ser_valid_i = 1'b0;
        bus.ser_first_i = 1'b0;
        bus.ser_bit_i   = 1'b0;
        bus.out_ready_i = 1'b1;

        #2;
        chk("rst_ser_ready", bus.ser_ready_o, 1);
        chk("rst_out_valid", bus.out_valid_o, 0);
        chk("rst_out_data",  bus.out_data_o,  0);
        chk("rst_out_err",   bus.out_err_o,   0);
        chk("rst_sticky",    err_sticky,      0);
        chk("rst_cnt",       err_cnt,         0);
        @(negedge clk);
        rst_n = 1'b1;

        // 1: good frame, ready held high
        send_data(8'hA5);
        chk("t1_no_early_valid", bus.out_valid_o, 0);
        send_bit(1'b0, 1'b0);
        chk("t1_valid", bus.out_valid_o, 1);
        chk("t1_data",  bus.out_data_o,  8'hA5);
        chk("t1_err",   bus.out_err_o,   0);
        chk("t1_ready_low", bus.ser_ready_o, 0);
        step();
        chk("t1_accepted", bus.out_valid_o, 0);
        chk("t1_ready_back", bus.ser_ready_o, 1);
        chk("t1_cnt", err_cnt, 0);
        chk("t1_sticky", err_sticky, 0);

        // 2: bad parity
        send_frame(8'h01, 1'b0);
        chk("t2_data", bus.out_data_o, 8'h01);
        chk("t2_err",  bus.out_err_o,  1);
        chk("t2_cnt_before_accept", err_cnt, 0);
        step();
        chk("t2_sticky", err_sticky, 1);
        chk("t2_cnt",    err_cnt,    1);

        // 3: backpressure hold
        bus.out_ready_i = 1'b0;
        send_frame(8'hC3, 1'b0);
        bus.ser_valid_i = 1'b1;
        bus.ser_first_i = 1'b1;
        bus.ser_bit_i   = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("t3_hold_ready", bus.ser_ready_o, 0);
            chk("t3_hold_valid", bus.out_valid_o, 1);
            chk("t3_hold_data",  bus.out_data_o,  8'hC3);
        end
        bus.ser_valid_i = 1'b0;
        bus.ser_first_i = 1'b0;
        bus.out_ready_i = 1'b1;
        step();
        chk("t3_released", bus.out_valid_o, 0);
        send_frame(8'h3C, 1'b0);
        chk("t3_next_data", bus.out_data_o, 8'h3C);
        chk("t3_next_err",  bus.out_err_o,  0);
        step();
        chk("t3_cnt", err_cnt, 1);

        // 4: saturation, then clear coinciding with a counted error
        for (int i = 0; i < 17; i++) begin
            send_frame(8'h01, 1'b0);
            step();
        end
        chk("t4_saturated", err_cnt, 15);
        send_frame(8'h01, 1'b0);
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;
        chk("t4_clr_inc_cnt",    err_cnt,    1);
        chk("t4_clr_inc_sticky", err_sticky, 1);
        @(negedge clk);
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;
        chk("t4_clr_cnt",    err_cnt,    0);
        chk("t4_clr_sticky", err_sticky, 0);

        // 5: abort after 4 bits, then full frame
        send_bit(1'b1, 1'b0);
        send_bit(1'b0, 1'b1);
        send_bit(1'b0, 1'b0);
        send_bit(1'b0, 1'b1);
        chk("t5_no_valid", bus.out_valid_o, 0);
        send_frame(8'hFF, 1'b0);
        chk("t5_valid", bus.out_valid_o, 1);
        chk("t5_data",  bus.out_data_o,  8'hFF);
        chk("t5_err",   bus.out_err_o,   0);
        step();
        chk("t5_cnt", err_cnt, 0);

        // 6: resets mid-SHIFT and in OUT
        send_frame(8'h07, 1'b0);
        step();
        chk("t6_pre_cnt", err_cnt, 1);
        send_bit(1'b1, 1'b1);
        send_bit(1'b0, 1'b1);
        send_bit(1'b0, 1'b0);
        rst_n = 1'b0;
        #1;
        chk("t6a_ser_ready", bus.ser_ready_o, 1);
        chk("t6a_out_valid", bus.out_valid_o, 0);
        chk("t6a_out_data",  bus.out_data_o,  0);
        chk("t6a_out_err",   bus.out_err_o,   0);
        chk("t6a_sticky",    err_sticky,      0);
        chk("t6a_cnt",       err_cnt,         0);
        @(negedge clk);
        rst_n = 1'b1;
        bus.out_ready_i = 1'b0;
        send_frame(8'h5A, 1'b1);
        chk("t6b_in_out", bus.out_valid_o, 1);
        chk("t6b_data",   bus.out_data_o,  8'h5A);
        rst_n = 1'b0;
        #1;
        chk("t6b_ser_ready", bus.ser_ready_o, 1);
        chk("t6b_out_valid", bus.out_valid_o, 0);
        chk("t6b_out_data",  bus.out_data_o,  0);
        chk("t6b_out_err",   bus.out_err_o,   0);
        @(negedge clk);
        rst_n = 1'b1;
        bus.out_ready_i = 1'b1;
        send_frame(8'h80, 1'b1);
        chk("t6c_valid", bus.out_valid_o, 1);
        chk("t6c_data",  bus.out_data_o,  8'h80);
        chk("t6c_err",   bus.out_err_o,   0);
        step();
        chk("t6c_cnt", err_cnt, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
